// File: rtl/apb_master_bridge_pkg.sv
// Purpose: shared types and default widths for the APB3 requester bridge.
//   APB_AW / APB_DW : default address / data widths
//   apb_state_e     : requester FSM state encoding
package apb_master_bridge_pkg;

  localparam int unsigned APB_AW      = 9;
  localparam int unsigned APB_DW      = 8;
  localparam int unsigned APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Completer select derived from the address MSB: 0 -> slave1, 1 -> slave2.
  function automatic logic [1:0] psel_decode(input logic addr_msb);
    return addr_msb ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Purpose: APB3 bus bundle between the requester bridge and the (muxed) completers.
//   master modport : drives psel1/psel2/penable/pwrite/paddr/pwdata,
//                    samples pready/prdata/pslverr
//   slave modport  : the mirror view for the completer side
interface apb_master_bridge_if
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned AW = APB_AW,
  parameter int unsigned DW = APB_DW
) ();

  logic          psel1;
  logic          psel2;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  modport master (
    output psel1, psel2, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel1, psel2, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Purpose: APB3 requester. Turns each test-side command into a SETUP->ACCESS
// transfer on the APB bus, decodes paddr[AW-1] into psel1/psel2, returns read
// data and flags slave errors and wait-state timeouts.
// Ports:
//   pclk, presetn      : clock, asynchronous active-low reset
//   transfer           : command request (sampled in IDLE and on ACCESS completion)
//   read_write         : 1 = read, 0 = write
//   apb_write_paddr    : write address
//   apb_write_data     : write data
//   apb_read_paddr     : read address
//   apb_read_data_out  : last completed read data, held until the next read completes
//   xfer_done          : one-cycle pulse per completion (normal, error or timeout)
//   xfer_err           : one-cycle pulse with xfer_done on PSLVERR or timeout
//   apb                : APB bus (master modport)
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned AW      = APB_AW,
  parameter int unsigned DW      = APB_DW,
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                transfer,
  input  logic                read_write,
  input  logic [AW-1:0]       apb_write_paddr,
  input  logic [DW-1:0]       apb_write_data,
  input  logic [AW-1:0]       apb_read_paddr,
  output logic [DW-1:0]       apb_read_data_out,
  output logic                xfer_done,
  output logic                xfer_err,
  apb_master_bridge_if.master apb
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e    state_q;
  logic          psel1_q;
  logic          psel2_q;
  logic          penable_q;
  logic          pwrite_q;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic [DW-1:0] rdata_q;
  logic          xfer_done_q;
  logic          xfer_err_q;
  logic [CNT_W-1:0] wait_cnt_q;

  // Command that would be captured this cycle if a transfer is accepted.
  logic [AW-1:0] cap_addr_c;
  logic [DW-1:0] cap_wdata_c;
  logic          cap_write_c;
  logic [1:0]    cap_sel_c;

  always_comb begin
    cap_write_c = ~read_write;
    cap_addr_c  = read_write ? apb_read_paddr : apb_write_paddr;
    cap_wdata_c = apb_write_data;
    cap_sel_c   = psel_decode(cap_addr_c[AW-1]);
  end

  // Abort when the last allowed ACCESS cycle also sees pready low.
  logic timeout_c;
  assign timeout_c = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  // Requester FSM; every bus and status output is a register of this block.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
      xfer_done_q <= 1'b0;
      xfer_err_q  <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      xfer_done_q <= 1'b0;
      xfer_err_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (transfer) begin
            state_q   <= SETUP;
            paddr_q   <= cap_addr_c;
            pwrite_q  <= cap_write_c;
            if (cap_write_c) pwdata_q <= cap_wdata_c;
            psel1_q   <= cap_sel_c[0];
            psel2_q   <= cap_sel_c[1];
            penable_q <= 1'b0;
          end
        end

        SETUP: begin
          state_q    <= ACCESS;
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
        end

        ACCESS: begin
          if (apb.pready) begin
            xfer_done_q <= 1'b1;
            xfer_err_q  <= apb.pslverr;
            // Error reads still return whatever the completer drove.
            if (!pwrite_q) rdata_q <= apb.prdata;
            if (transfer) begin
              // Back-to-back: go straight to SETUP of the next command.
              state_q   <= SETUP;
              paddr_q   <= cap_addr_c;
              pwrite_q  <= cap_write_c;
              if (cap_write_c) pwdata_q <= cap_wdata_c;
              psel1_q   <= cap_sel_c[0];
              psel2_q   <= cap_sel_c[1];
              penable_q <= 1'b0;
            end else begin
              state_q   <= IDLE;
              psel1_q   <= 1'b0;
              psel2_q   <= 1'b0;
              penable_q <= 1'b0;
            end
          end else if (timeout_c) begin
            // Abort: report an error, keep read data, ignore transfer this cycle.
            xfer_done_q <= 1'b1;
            xfer_err_q  <= 1'b1;
            state_q     <= IDLE;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q   <= IDLE;
          psel1_q   <= 1'b0;
          psel2_q   <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign apb.psel1         = psel1_q;
  assign apb.psel2         = psel2_q;
  assign apb.penable       = penable_q;
  assign apb.pwrite        = pwrite_q;
  assign apb.paddr         = paddr_q;
  assign apb.pwdata        = pwdata_q;
  assign apb_read_data_out = rdata_q;
  assign xfer_done         = xfer_done_q;
  assign xfer_err          = xfer_err_q;

  // Bus sanity: selects are never both high, and penable implies a select.
  a_psel_onehot: assert property (@(posedge pclk) disable iff (!presetn)
    !(psel1_q && psel2_q));
  a_penable_sel: assert property (@(posedge pclk) disable iff (!presetn)
    penable_q |-> (psel1_q || psel2_q));
  a_err_with_done: assert property (@(posedge pclk) disable iff (!presetn)
    xfer_err_q |-> xfer_done_q);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose: self-checking bench for apb_master_bridge. Completion results
// (error flag, read data) are queued when a command is issued and checked
// by a monitor when xfer_done pulses; bus timing is checked inline per test.
module tb_apb_master_bridge;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          pclk;
  logic          presetn;
  logic          transfer;
  logic          read_write;
  logic [AW-1:0] apb_write_paddr;
  logic [DW-1:0] apb_write_data;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_read_data_out;
  logic          xfer_done;
  logic          xfer_err;

  apb_master_bridge_if #(.AW(AW), .DW(DW)) apb ();

  apb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out),
    .xfer_done         (xfer_done),
    .xfer_err          (xfer_err),
    .apb               (apb)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            passed = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic push_exp(input logic err, input logic [DW-1:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every completion must match the oldest queued result.
  always @(negedge pclk) begin
    if (presetn && xfer_done) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_done: xfer_done=1 with no transfer outstanding");
      end else begin
        mon_e = sb.pop_front();
        if (xfer_err !== mon_e.err)
          $display("FAIL done_err: got %0b expected %0b", xfer_err, mon_e.err);
        else if (apb_read_data_out !== mon_e.rdata)
          $display("FAIL done_rdata: got 0x%0h expected 0x%0h", apb_read_data_out, mon_e.rdata);
        else
          passed++;
      end
    end
    if (presetn && xfer_err && !xfer_done) begin
      checks++;
      $display("FAIL err_without_done: xfer_err=1 xfer_done=0");
    end
  end

  task automatic test_reset();
    presetn = 1'b0; transfer = 1'b0; read_write = 1'b0;
    apb_write_paddr = '0; apb_write_data = '0; apb_read_paddr = '0;
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
    repeat (3) tick();
    checks++;
    if ({apb.psel1, apb.psel2, apb.penable, apb.pwrite} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {apb.psel1, apb.psel2, apb.penable, apb.pwrite});
    else passed++;
    checks++;
    if (apb.paddr !== 9'h000 || apb.pwdata !== 8'h00)
      $display("FAIL reset_bus: paddr=0x%0h pwdata=0x%0h expected 0", apb.paddr, apb.pwdata);
    else passed++;
    checks++;
    if (xfer_done !== 1'b0 || xfer_err !== 1'b0 || apb_read_data_out !== 8'h00)
      $display("FAIL reset_status: done=%b err=%b rdata=0x%0h expected 0", xfer_done, xfer_err, apb_read_data_out);
    else passed++;
    presetn = 1'b1;
    last_rd = '0;
    tick();
  endtask

  task automatic test_write();
    read_write = 1'b0; apb_write_paddr = 9'h0A5; apb_write_data = 8'h3C;
    apb.pready = 1'b1; apb.pslverr = 1'b0; transfer = 1'b1;
    push_exp(1'b0, last_rd);
    tick();
    transfer = 1'b0;
    checks++;
    if ({apb.psel1, apb.psel2, apb.penable, apb.pwrite} !== 4'b1001 || apb.paddr !== 9'h0A5 || apb.pwdata !== 8'h3C)
      $display("FAIL write_setup: sel/en/wr=%b paddr=0x%0h pwdata=0x%0h expected 1001/0a5/3c",
               {apb.psel1, apb.psel2, apb.penable, apb.pwrite}, apb.paddr, apb.pwdata);
    else passed++;
    tick();
    checks++;
    if ({apb.psel1, apb.penable, xfer_done} !== 3'b110)
      $display("FAIL write_access: sel1/en/done=%b expected 110", {apb.psel1, apb.penable, xfer_done});
    else passed++;
    tick();
    checks++;
    if ({xfer_done, apb.psel1, apb.penable} !== 3'b100)
      $display("FAIL write_latency: done/sel1/en=%b expected 100", {xfer_done, apb.psel1, apb.penable});
    else passed++;
  endtask

  task automatic test_read_wait();
    int  en_cnt;
    bit  seen;
    en_cnt = 0; seen = 0;
    read_write = 1'b1; apb_read_paddr = 9'h1F0;
    apb.pready = 1'b0; apb.prdata = 8'h00; apb.pslverr = 1'b0; transfer = 1'b1;
    push_exp(1'b0, 8'h5A);
    last_rd = 8'h5A;
    tick();
    transfer = 1'b0;
    checks++;
    if ({apb.psel1, apb.psel2, apb.pwrite} !== 3'b010 || apb.paddr !== 9'h1F0)
      $display("FAIL read_setup: sel1/sel2/wr=%b paddr=0x%0h expected 010/1f0",
               {apb.psel1, apb.psel2, apb.pwrite}, apb.paddr);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      if (xfer_done) begin seen = 1; break; end
      if (apb.penable) en_cnt++;
      apb.pready = (en_cnt == 3);
      apb.prdata = (en_cnt == 3) ? 8'h5A : 8'h00;
      tick();
    end
    apb.pready = 1'b0;
    checks++;
    if (!seen || en_cnt != 3)
      $display("FAIL read_wait: done_seen=%0b penable_cycles=%0d expected 1/3", seen, en_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit rd;
    apb.pready = 1'b1; apb.pslverr = 1'b0;
    apb_write_paddr = 9'h010; apb_read_paddr = 9'h110;
    read_write = 1'b0; apb_write_data = 8'hA0; transfer = 1'b1;
    push_exp(1'b0, last_rd);
    tick();
    for (int i = 0; i < 4; i++) begin
      rd = i[0];
      checks++;
      if (apb.penable !== 1'b0 || apb.psel2 !== rd || apb.pwrite !== !rd ||
          apb.paddr !== (rd ? 9'h110 : 9'h010) || (!rd && apb.pwdata !== 8'(8'hA0 + i)))
        $display("FAIL b2b_setup%0d: en=%b sel2=%b wr=%b paddr=0x%0h pwdata=0x%0h",
                 i, apb.penable, apb.psel2, apb.pwrite, apb.paddr, apb.pwdata);
      else passed++;
      apb.prdata = 8'(8'h30 + i);
      if (i < 3) begin
        read_write = ~rd;
        apb_write_data = 8'(8'hA0 + i + 1);
        if (!rd) last_rd = 8'(8'h30 + i + 1);
        push_exp(1'b0, last_rd);
      end else begin
        transfer = 1'b0;
      end
      tick();
      checks++;
      if (apb.penable !== 1'b1 || xfer_done !== 1'b0)
        $display("FAIL b2b_access%0d: en=%b done=%b expected 1/0", i, apb.penable, xfer_done);
      else passed++;
      tick();
      checks++;
      if (xfer_done !== 1'b1)
        $display("FAIL b2b_done%0d: done=%b expected 1", i, xfer_done);
      else passed++;
    end
    checks++;
    if (apb.psel1 !== 1'b0 || apb.psel2 !== 1'b0)
      $display("FAIL b2b_idle: sel1=%b sel2=%b expected 0/0", apb.psel1, apb.psel2);
    else passed++;
  endtask

  task automatic test_timeout();
    int n_access;
    bit seen;
    n_access = 0; seen = 0;
    read_write = 1'b1; apb_read_paddr = 9'h020;
    apb.pready = 1'b0; apb.prdata = 8'hEE; apb.pslverr = 1'b0; transfer = 1'b1;
    push_exp(1'b1, last_rd);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (xfer_done) begin seen = 1; break; end
      if (apb.penable) n_access++;
    end
    checks++;
    if (!seen || n_access != TO)
      $display("FAIL timeout_len: done_seen=%0b access_cycles=%0d expected 1/%0d", seen, n_access, TO);
    else passed++;
    // transfer was still high on the abort edge; it must not have started a new transfer.
    checks++;
    if (apb.psel1 !== 1'b0 || apb.psel2 !== 1'b0 || apb.penable !== 1'b0)
      $display("FAIL timeout_idle: sel1=%b sel2=%b en=%b expected 000", apb.psel1, apb.psel2, apb.penable);
    else passed++;
    transfer = 1'b0;
    tick();
  endtask

  task automatic test_slverr();
    // Write to slave2 with PSLVERR at completion.
    read_write = 1'b0; apb_write_paddr = 9'h105; apb_write_data = 8'h11;
    apb.pready = 1'b1; apb.pslverr = 1'b1; transfer = 1'b1;
    push_exp(1'b1, last_rd);
    tick(); transfer = 1'b0;
    checks++;
    if (apb.psel2 !== 1'b1 || apb.psel1 !== 1'b0)
      $display("FAIL slverr_sel: sel1=%b sel2=%b expected 0/1", apb.psel1, apb.psel2);
    else passed++;
    tick(); tick();
    checks++;
    if (xfer_done !== 1'b1 || xfer_err !== 1'b1)
      $display("FAIL slverr_write: done=%b err=%b expected 1/1", xfer_done, xfer_err);
    else passed++;
    // Errored read still updates read data.
    read_write = 1'b1; apb_read_paddr = 9'h0FF; apb.prdata = 8'h77; transfer = 1'b1;
    push_exp(1'b1, 8'h77);
    last_rd = 8'h77;
    tick(); transfer = 1'b0;
    tick(); tick();
    checks++;
    if (xfer_done !== 1'b1 || apb_read_data_out !== 8'h77)
      $display("FAIL slverr_read: done=%b rdata=0x%0h expected 1/77", xfer_done, apb_read_data_out);
    else passed++;
    // Next transfer normal; pslverr during a wait state is ignored.
    read_write = 1'b0; apb_write_paddr = 9'h006; apb_write_data = 8'h22;
    apb.pready = 1'b0; apb.pslverr = 1'b1; transfer = 1'b1;
    push_exp(1'b0, last_rd);
    tick(); transfer = 1'b0;
    tick(); tick();
    checks++;
    if (apb.penable !== 1'b1 || xfer_done !== 1'b0)
      $display("FAIL slverr_wait: en=%b done=%b expected 1/0", apb.penable, xfer_done);
    else passed++;
    apb.pready = 1'b1; apb.pslverr = 1'b0;
    tick();
    checks++;
    if (xfer_done !== 1'b1 || xfer_err !== 1'b0)
      $display("FAIL slverr_recover: done=%b err=%b expected 1/0", xfer_done, xfer_err);
    else passed++;
  endtask

  task automatic test_reset_mid();
    read_write = 1'b0; apb_write_paddr = 9'h1AA; apb_write_data = 8'h55;
    apb.pready = 1'b0; apb.pslverr = 1'b0; transfer = 1'b1;
    tick(); transfer = 1'b0;
    tick();
    checks++;
    if (apb.penable !== 1'b1 || apb.psel2 !== 1'b1)
      $display("FAIL rstmid_access: en=%b sel2=%b expected 1/1", apb.penable, apb.psel2);
    else passed++;
    #2 presetn = 1'b0;
    #1;
    checks++;
    if (apb.psel1 !== 1'b0 || apb.psel2 !== 1'b0 || apb.penable !== 1'b0 || apb.paddr !== 9'h000)
      $display("FAIL rstmid_async: sel1=%b sel2=%b en=%b paddr=0x%0h expected 0",
               apb.psel1, apb.psel2, apb.penable, apb.paddr);
    else passed++;
    apb.pready = 1'b1;
    tick();
    presetn = 1'b1;
    last_rd = '0;
    repeat (4) tick();
    checks++;
    if (apb.psel1 !== 1'b0 || apb.psel2 !== 1'b0 || apb_read_data_out !== 8'h00)
      $display("FAIL rstmid_idle: sel1=%b sel2=%b rdata=0x%0h expected 0",
               apb.psel1, apb.psel2, apb_read_data_out);
    else passed++;
    // FSM must accept a fresh command from IDLE.
    read_write = 1'b1; apb_read_paddr = 9'h040; apb.prdata = 8'h99; transfer = 1'b1;
    push_exp(1'b0, 8'h99);
    last_rd = 8'h99;
    tick(); transfer = 1'b0;
    tick(); tick();
    checks++;
    if (xfer_done !== 1'b1 || apb_read_data_out !== 8'h99)
      $display("FAIL rstmid_after: done=%b rdata=0x%0h expected 1/99", xfer_done, apb_read_data_out);
    else passed++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d completions outstanding expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
